// File: rtl/lcd_text_refresh.sv
// rtl/lcd_text_refresh.sv - HD44780-style character LCD driver: power-up, init, then whole-frame text refresh.
// Every command and character goes through one SETUP / EN_HI / HOLD / WAIT write cycle.
module lcd_text_refresh #(
  parameter int ROWS         = 2,
  parameter int COLS         = 16,
  parameter int EN_CYCLES    = 16,
  parameter int CHAR_DLY     = 262142,
  parameter int CLR_DLY      = 262142,
  parameter int PWR_DLY      = 1000000,
  parameter int AUTO_REFRESH = 1,
  parameter int FILTER_CTRL  = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [ROWS*COLS*8-1:0] TEXT,
  input  logic                   UPDATE_REQ,
  output logic                   BUSY,
  output logic                   FRAME_DONE,
  output logic [7:0]             LCD_DATA,
  output logic                   LCD_RS,
  output logic                   LCD_RW,
  output logic                   LCD_EN,
  output logic                   LCD_ON,
  output logic                   LCD_BLON
);

  localparam int RW   = $clog2(ROWS) + 1;
  localparam int CLW  = $clog2(COLS) + 1;
  localparam int MAX1 = (PWR_DLY > CHAR_DLY) ? PWR_DLY : CHAR_DLY;
  localparam int MAX2 = (CLR_DLY > EN_CYCLES) ? CLR_DLY : EN_CYCLES;
  localparam int MAXV = (MAX1 > MAX2) ? MAX1 : MAX2;
  localparam int CW   = $clog2(MAXV + 1) + 1;

  localparam logic [CW-1:0] PWR_LAST = CW'(PWR_DLY - 1);
  localparam logic [CW-1:0] EN_LEN   = CW'(EN_CYCLES);
  localparam logic [CW-1:0] CHAR_LEN = CW'(CHAR_DLY);
  localparam logic [CW-1:0] CLR_LEN  = CW'(CLR_DLY);

  typedef enum logic [2:0] {
    S_PWR, S_SETUP, S_EN, S_HOLD, S_WAIT, S_DONE, S_IDLE
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   init_q;
  logic [1:0]             idx_q;
  logic [RW-1:0]          row_q;
  logic [CLW-1:0]         col_q;
  logic                   pending_q;
  logic [ROWS*COLS*8-1:0] buf_q;
  logic                   en_q;
  logic                   rs_q;
  logic [7:0]             data_q;
  logic                   busy_q;
  logic                   done_q;

  logic                   init_d;
  logic [1:0]             idx_d;
  logic [RW-1:0]          row_d;
  logic [CLW-1:0]         col_d;
  logic                   rs_d;
  logic [7:0]             data_d;
  logic                   enter_frame;
  logic                   last_write;
  logic                   write_done;
  logic                   go_frame;
  logic [CW-1:0]          dly_w;
  logic [7:0]             ch;
  int                     char_idx;

  // Only the clear-display command needs the long wait; 0x01 as a data byte does not.
  assign dly_w      = (!rs_q && data_q == 8'h01) ? CLR_LEN : CHAR_LEN;
  assign write_done = (state_q == S_HOLD && dly_w == '0) ||
                      (state_q == S_WAIT && cnt_q == CW'(1));
  assign last_write = !init_q && int'(col_q) == COLS && int'(row_q) == ROWS - 1;
  assign go_frame   = UPDATE_REQ || (state_q == S_DONE && (AUTO_REFRESH != 0 || pending_q));

  // Position of the write that follows the current one; col 0 is the row address command.
  always_comb begin
    init_d      = init_q;
    idx_d       = idx_q;
    row_d       = row_q;
    col_d       = col_q;
    enter_frame = 1'b0;
    if (init_q) begin
      if (idx_q == 2'd3) begin
        init_d      = 1'b0;
        row_d       = '0;
        col_d       = '0;
        enter_frame = 1'b1;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end else if (int'(col_q) < COLS) begin
      col_d = col_q + CLW'(1);
    end else begin
      row_d = row_q + RW'(1);
      col_d = '0;
    end
  end

  always_comb begin
    char_idx = int'(row_d) * COLS + int'(col_d) - 1;
    ch       = 8'h00;
    for (int k = 0; k < ROWS * COLS; k++) begin
      if (k == char_idx) ch = buf_q[(ROWS*COLS-1-k)*8 +: 8];
    end
  end

  always_comb begin
    rs_d   = 1'b0;
    data_d = 8'h00;
    if (init_d) begin
      case (idx_d)
        2'd0:    data_d = 8'h38;
        2'd1:    data_d = 8'h0C;
        2'd2:    data_d = 8'h01;
        default: data_d = 8'h06;
      endcase
    end else if (col_d == '0) begin
      case (int'(row_d))
        0:       data_d = 8'h80;
        1:       data_d = 8'hC0;
        2:       data_d = 8'h80 + 8'(COLS);
        default: data_d = 8'hC0 + 8'(COLS);
      endcase
    end else begin
      rs_d   = 1'b1;
      data_d = ch;
      if (FILTER_CTRL != 0 && (ch < 8'h20 || ch == 8'h7F)) data_d = 8'h20;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_PWR;
      cnt_q     <= '0;
      init_q    <= 1'b0;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      pending_q <= 1'b0;
      buf_q     <= '0;
      en_q      <= 1'b0;
      rs_q      <= 1'b0;
      data_q    <= 8'h00;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (UPDATE_REQ && state_q != S_IDLE && state_q != S_DONE) pending_q <= 1'b1;
      if (write_done) begin
        if (last_write) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end else begin
          state_q <= S_SETUP;
          init_q  <= init_d;
          idx_q   <= idx_d;
          row_q   <= row_d;
          col_q   <= col_d;
          rs_q    <= rs_d;
          data_q  <= data_d;
          if (enter_frame) buf_q <= TEXT;
        end
      end else begin
        case (state_q)
          S_PWR: begin
            if (cnt_q == PWR_LAST) begin
              state_q <= S_SETUP;
              cnt_q   <= '0;
              init_q  <= 1'b1;
              idx_q   <= '0;
              rs_q    <= 1'b0;
              data_q  <= 8'h38;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_SETUP: begin
            state_q <= S_EN;
            en_q    <= 1'b1;
            cnt_q   <= EN_LEN;
          end
          S_EN: begin
            if (cnt_q == CW'(1)) begin
              state_q <= S_HOLD;
              en_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          S_HOLD: begin
            state_q <= S_WAIT;
            cnt_q   <= dly_w;
          end
          S_WAIT: cnt_q <= cnt_q - CW'(1);
          S_DONE, S_IDLE: begin
            pending_q <= 1'b0;
            if (go_frame) begin
              state_q <= S_SETUP;
              busy_q  <= 1'b1;
              init_q  <= 1'b0;
              row_q   <= '0;
              col_q   <= '0;
              rs_q    <= 1'b0;
              data_q  <= 8'h80;
              buf_q   <= TEXT;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= S_PWR;
        endcase
      end
    end
  end

  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;
  assign LCD_DATA   = data_q;
  assign LCD_RS     = rs_q;
  assign LCD_EN     = en_q;
  assign LCD_RW     = 1'b0;
  assign LCD_ON     = 1'b1;
  assign LCD_BLON   = 1'b1;

endmodule

// File: tb/tb_lcd_text_refresh.sv
// tb/tb_lcd_text_refresh.sv - self-checking bench for lcd_text_refresh against a frame/timing model.
module tb_lcd_text_refresh;
  localparam int R  = 2;
  localparam int C  = 4;
  localparam int EN = 2;
  localparam int CD = 4;
  localparam int LD = 8;
  localparam int PD = 10;
  localparam int WR = EN + 2 + CD;
  localparam int FW = R * (C + 1);

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [R*C*8-1:0] TEXT;
  logic         UPDATE_REQ;

  logic busy, fd, rs, rw, en, on, blon;
  logic [7:0] data;
  logic nf_busy, nf_fd, nf_rs, nf_rw, nf_en, nf_on, nf_blon;
  logic [7:0] nf_data;
  logic au_busy, au_fd, au_rs, au_rw, au_en, au_on, au_blon;
  logic [7:0] au_data;

  always #5 CLK = ~CLK;

  lcd_text_refresh #(.ROWS(R), .COLS(C), .EN_CYCLES(EN), .CHAR_DLY(CD), .CLR_DLY(LD),
    .PWR_DLY(PD), .AUTO_REFRESH(0), .FILTER_CTRL(1)) dut (
    .CLK(CLK), .RST_N(RST_N), .TEXT(TEXT), .UPDATE_REQ(UPDATE_REQ), .BUSY(busy),
    .FRAME_DONE(fd), .LCD_DATA(data), .LCD_RS(rs), .LCD_RW(rw), .LCD_EN(en),
    .LCD_ON(on), .LCD_BLON(blon));

  lcd_text_refresh #(.ROWS(R), .COLS(C), .EN_CYCLES(EN), .CHAR_DLY(CD), .CLR_DLY(LD),
    .PWR_DLY(PD), .AUTO_REFRESH(0), .FILTER_CTRL(0)) dut_nf (
    .CLK(CLK), .RST_N(RST_N), .TEXT(TEXT), .UPDATE_REQ(UPDATE_REQ), .BUSY(nf_busy),
    .FRAME_DONE(nf_fd), .LCD_DATA(nf_data), .LCD_RS(nf_rs), .LCD_RW(nf_rw), .LCD_EN(nf_en),
    .LCD_ON(nf_on), .LCD_BLON(nf_blon));

  lcd_text_refresh #(.ROWS(R), .COLS(C), .EN_CYCLES(EN), .CHAR_DLY(CD), .CLR_DLY(LD),
    .PWR_DLY(PD), .AUTO_REFRESH(1), .FILTER_CTRL(1)) dut_au (
    .CLK(CLK), .RST_N(RST_N), .TEXT(TEXT), .UPDATE_REQ(UPDATE_REQ), .BUSY(au_busy),
    .FRAME_DONE(au_fd), .LCD_DATA(au_data), .LCD_RS(au_rs), .LCD_RW(au_rw), .LCD_EN(au_en),
    .LCD_ON(au_on), .LCD_BLON(au_blon));

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise;
    int         width;
    logic       stable;
  } wr_t;

  wr_t        wq[$];
  int         fdq[$];
  int         afq[$];
  logic [7:0] nfq[$];
  logic [9:0] exp_q[$];   // {frame ends after this write, rs, data}

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  logic       en_prev = 1'b0;
  logic       nf_prev = 1'b0;
  int         rise_t  = 0;
  logic [8:0] rd      = '0;
  logic       stb     = 1'b0;

  // Bus monitor: one record per EN pulse, sampled on the falling clock edge.
  always @(negedge CLK) begin
    if (en && !en_prev) begin
      rise_t = cyc;
      rd     = {rs, data};
      stb    = 1'b1;
    end
    if ((en || en_prev) && {rs, data} !== rd) stb = 1'b0;
    if (!en && en_prev) wq.push_back('{rs: rd[8], data: rd[7:0], rise: rise_t, width: cyc - rise_t, stable: stb});
    en_prev = en;
    if (fd) fdq.push_back(cyc);
    if (nf_en && !nf_prev && nf_rs) nfq.push_back(nf_data);
    nf_prev = nf_en;
    if (au_fd) afq.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int gap_after(input logic [9:0] x);
    return EN + 2 + ((x[8:0] == 9'h001) ? LD : CD) + (x[9] ? 1 : 0);
  endfunction

  task automatic add_init();
    exp_q.push_back(10'h038);
    exp_q.push_back(10'h00C);
    exp_q.push_back(10'h001);
    exp_q.push_back(10'h006);
  endtask

  task automatic add_frame(input logic [R*C*8-1:0] t, input bit filt);
    for (int r = 0; r < R; r++) begin
      logic [7:0] base;
      base = ((r % 2 == 1) ? 8'hC0 : 8'h80) + ((r >= 2) ? 8'(C) : 8'h00);
      exp_q.push_back({2'b00, base});
      for (int c = 0; c < C; c++) begin
        logic [7:0] b;
        b = t[(R*C-1-(r*C+c))*8 +: 8];
        if (filt && (b < 8'h20 || b == 8'h7F)) b = 8'h20;
        exp_q.push_back({(r == R-1 && c == C-1), 1'b1, b});
      end
    end
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
      chk($sformatf("%s_w%0d", tag, i), {wq[i].rs, wq[i].data}, exp_q[i][8:0]);
      chk($sformatf("%s_en%0d", tag, i), wq[i].width, EN);
      chk($sformatf("%s_stable%0d", tag, i), wq[i].stable, 1);
      if (i > 0) chk($sformatf("%s_gap%0d", tag, i), wq[i].rise - wq[i-1].rise, gap_after(exp_q[i-1]));
    end
  endtask

  task automatic check_fd(input string tag, input int n);
    chk({tag, "_fd_count"}, fdq.size(), n);
    if (fdq.size() == n && wq.size() > 0)
      chk({tag, "_fd_time"}, fdq[n-1], wq[wq.size()-1].rise + EN + 1 + CD);
  endtask

  task automatic clear_all();
    wq.delete(); fdq.delete(); afq.delete(); nfq.delete(); exp_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge CLK);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_timeout"}, n < budget, 1);
  endtask

  task automatic request(output int q);
    @(negedge CLK);
    clear_all();
    UPDATE_REQ = 1'b1;
    q = cyc;
    @(negedge CLK);
    UPDATE_REQ = 1'b0;
  endtask

  task automatic pulse_req();
    @(negedge CLK);
    UPDATE_REQ = 1'b1;
    @(negedge CLK);
    UPDATE_REQ = 1'b0;
  endtask

  initial begin
    int c0, q, n;
    logic [R*C*8-1:0] ta, tb2;

    RST_N = 1'b0;
    UPDATE_REQ = 1'b0;
    TEXT = "ABCDEFGH";
    repeat (3) @(negedge CLK);
    chk("rst_en", en, 0);
    chk("rst_rs", rs, 0);
    chk("rst_data", data, 8'h00);
    chk("rst_busy", busy, 1);
    chk("rst_fd", fd, 0);
    chk("const_pins", {rw, on, blon}, 3'b011);

    // Power-up, init and the unconditional first frame.
    clear_all();
    c0 = cyc;
    RST_N = 1'b1;
    wait_idle("boot", 400);
    add_init();
    add_frame(TEXT, 1'b1);
    check_writes("boot");
    if (wq.size() > 0) chk("boot_pwr_wait", wq[0].rise - c0, PD + 1);
    check_fd("boot", 1);
    chk("boot_idle_busy", busy, 0);

    // Random frames on request; TEXT changes mid-frame must not tear.
    for (int k = 0; k < 3; k++) begin
      ta = {$urandom, $urandom};
      TEXT = ta;
      request(q);
      repeat (5) @(negedge CLK);
      TEXT = "ZZZZZZZZ";
      wait_idle($sformatf("snap%0d", k), 200);
      add_frame(ta, 1'b1);
      check_writes($sformatf("snap%0d", k));
      if (wq.size() > 0) chk($sformatf("snap%0d_latency", k), wq[0].rise, q + 2);
      check_fd($sformatf("snap%0d", k), 1);
    end

    // Three mid-frame requests collapse into one extra frame that snapshots the newer text.
    ta = {$urandom, $urandom};
    tb2 = {$urandom, $urandom};
    TEXT = ta;
    request(q);
    repeat (8) @(negedge CLK);
    pulse_req();
    TEXT = tb2;
    repeat (18) @(negedge CLK);
    pulse_req();
    repeat (18) @(negedge CLK);
    pulse_req();
    wait_idle("pend", 400);
    repeat (30) @(negedge CLK);
    add_frame(ta, 1'b1);
    add_frame(tb2, 1'b1);
    check_writes("pend");
    check_fd("pend", 2);
    chk("pend_idle_busy", busy, 0);

    // Control characters: filtered on the main instance, raw on the unfiltered one.
    ta = {$urandom, $urandom};
    ta[15:8] = 8'h0A;
    ta[7:0]  = 8'h7F;
    TEXT = ta;
    request(q);
    wait_idle("filt", 200);
    add_frame(ta, 1'b1);
    check_writes("filt");
    if (wq.size() > 8) chk("filt_r1c2", wq[8].data, 8'h20);
    chk("nofilt_count", nfq.size(), R * C);
    for (int i = 0; i < R * C && i < nfq.size(); i++)
      chk($sformatf("nofilt_c%0d", i), nfq[i], ta[(R*C-1-i)*8 +: 8]);

    // Reset in the middle of a character's EN pulse.
    request(q);
    n = 0;
    while (!(en === 1'b1 && rs === 1'b1) && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_mid_found", n < 200, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_mid_en", en, 0);
    chk("rst_mid_data", data, 8'h00);
    chk("rst_mid_busy", busy, 1);
    repeat (2) @(negedge CLK);
    clear_all();
    c0 = cyc;
    RST_N = 1'b1;
    wait_idle("reboot", 400);
    add_init();
    add_frame(TEXT, 1'b1);
    check_writes("reboot");
    if (wq.size() > 0) chk("reboot_pwr_wait", wq[0].rise - c0, PD + 1);
    check_fd("reboot", 1);

    // Auto-refresh instance: back-to-back frames separated only by the DONE cycle.
    n = 0;
    while (afq.size() < 3 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("auto_timeout", afq.size() >= 3, 1);
    if (afq.size() >= 3 && fdq.size() > 0) begin
      chk("auto_first_fd", afq[0], fdq[0]);
      chk("auto_period1", afq[1] - afq[0], FW * WR + 1);
      chk("auto_period2", afq[2] - afq[1], FW * WR + 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
